// File: rtl/control_unit_pkg.sv
// Shared types and constants for the RV32I multi-cycle control unit.
// Branch support is compiled in with CTRL_BRANCH_EN.
package control_unit_pkg;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned REG_AW = 5;

   typedef enum logic [2:0] {
      OPND_RS1,
      OPND_RS2,
      OPND_IMM,
      OPND_PC,
      OPND_ZERO,
      OPND_FOUR
   } alu_operand_t;

   typedef enum logic [3:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_SLL,
      ALU_SLT,
      ALU_SLTU,
      ALU_XOR,
      ALU_SRL,
      ALU_SRA,
      ALU_OR,
      ALU_AND,
      ALU_EQ,
      ALU_NE,
      ALU_LT,
      ALU_GE,
      ALU_LTU,
      ALU_GEU
   } alu_operation_t;

   typedef enum logic [2:0] {
      IMM_NONE,
      IMM_I,
      IMM_U,
      IMM_J,
      IMM_B
   } imm_fmt_t;

   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;

   localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
   localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

   // Control state encoding
   localparam logic [2:0] ST_FETCH     = 3'd0;
   localparam logic [2:0] ST_DECODE    = 3'd1;
   localparam logic [2:0] ST_EXECUTE   = 3'd2;
   localparam logic [2:0] ST_PC_UPDATE = 3'd3;
   localparam logic [2:0] ST_TRAP      = 3'd4;

   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

   // Immediate format selected by the major opcode
   function automatic imm_fmt_t imm_fmt(input logic [6:0] opcode);
      imm_fmt_t fmt;
      case (opcode)
         OPC_OP_IMM, OPC_JALR: fmt = IMM_I;
         OPC_LUI, OPC_AUIPC:   fmt = IMM_U;
         OPC_JAL:              fmt = IMM_J;
`ifdef CTRL_BRANCH_EN
         OPC_BRANCH:           fmt = IMM_B;
`endif
         default:              fmt = IMM_NONE;
      endcase
      return fmt;
   endfunction

   // Arithmetic/logic op; alt selects SUB/SRA where the encoding allows it
   function automatic alu_operation_t arith_op(input logic [2:0] funct3, input logic alt);
      alu_operation_t op;
      case (funct3)
         3'b000:  op = alt ? ALU_SUB : ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = alt ? ALU_SRA : ALU_SRL;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

   function automatic alu_operation_t branch_op(input logic [2:0] funct3);
      alu_operation_t op;
      case (funct3)
         3'b001:  op = ALU_NE;
         3'b100:  op = ALU_LT;
         3'b101:  op = ALU_GE;
         3'b110:  op = ALU_LTU;
         3'b111:  op = ALU_GEU;
         default: op = ALU_EQ;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/control_unit_if.sv
// Fetch port and datapath control bundle between control_unit and the core.
interface control_unit_if;
   import control_unit_pkg::*;

   logic                  mem_req;
   logic [XLEN-1:0]       mem_addr;
   logic                  mem_ready;
   logic [XLEN-1:0]       mem_rdata;
   logic [XLEN-1:0]       pc_in;
   logic [XLEN-1:0]       alu_result;
   logic [REG_AW-1:0]     reg_bank_sel_out_a;
   logic [REG_AW-1:0]     reg_bank_sel_out_b;
   logic [REG_AW-1:0]     reg_bank_sel_in;
   logic                  reg_bank_load_en;
   logic                  pc_load_en;
   logic [XLEN-1:0]       alu_immediate_data;
   alu_operand_t          alu_operand_a_select;
   alu_operand_t          alu_operand_b_select;
   alu_operation_t        alu_operation;
   logic                  bus_clear_lsb;
   logic                  instr_retired;
   logic                  illegal_instr;

   modport master (
      output mem_req, mem_addr, reg_bank_sel_out_a, reg_bank_sel_out_b, reg_bank_sel_in,
             reg_bank_load_en, pc_load_en, alu_immediate_data, alu_operand_a_select,
             alu_operand_b_select, alu_operation, bus_clear_lsb, instr_retired, illegal_instr,
      input  mem_ready, mem_rdata, pc_in, alu_result
   );

   modport slave (
      input  mem_req, mem_addr, reg_bank_sel_out_a, reg_bank_sel_out_b, reg_bank_sel_in,
             reg_bank_load_en, pc_load_en, alu_immediate_data, alu_operand_a_select,
             alu_operand_b_select, alu_operation, bus_clear_lsb, instr_retired, illegal_instr,
      output mem_ready, mem_rdata, pc_in, alu_result
   );

endinterface

// File: rtl/control_unit_imm_gen.sv
// Combinational immediate extraction from the instruction register.
// B-format is produced only when CTRL_BRANCH_EN is defined.
module control_unit_imm_gen
   import control_unit_pkg::*;
(
   input  logic [XLEN-1:0] ir,
   output logic [XLEN-1:0] imm_c
);

   always_comb begin
      imm_c = '0;
      case (imm_fmt(ir[6:0]))
         IMM_I:   imm_c = {{20{ir[31]}}, ir[31:20]};
         IMM_U:   imm_c = {ir[31:12], 12'b0};
         IMM_J:   imm_c = {{12{ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};
         IMM_B:   imm_c = {{20{ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0};
         default: imm_c = '0;
      endcase
   end

endmodule

// File: rtl/control_unit.sv
// RV32I multi-cycle fetch/decode/sequencing controller (FETCH, DECODE, EXECUTE, PC_UPDATE, TRAP).
// Optional macro CTRL_BRANCH_EN enables conditional branches.
module control_unit
   import control_unit_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   control_unit_if.master bus
);

   logic [2:0]        state;
   logic [2:0]        next_state;
   logic [XLEN-1:0]   ir;

   logic [6:0]        opcode;
   logic [2:0]        funct3;
   logic [6:0]        funct7;
   logic [REG_AW-1:0] rd;

   logic              dec_legal;
   logic              dec_writes_rd;
   alu_operand_t      dec_a;
   alu_operand_t      dec_b;
   alu_operation_t    dec_op;

   assign opcode = ir[6:0];
   assign rd     = ir[11:7];
   assign funct3 = ir[14:12];
   assign funct7 = ir[31:25];

   assign bus.mem_addr           = bus.pc_in;
   assign bus.reg_bank_sel_out_a = ir[19:15];
   assign bus.reg_bank_sel_out_b = ir[24:20];
   assign bus.reg_bank_sel_in    = rd;

   control_unit_imm_gen u_imm_gen (
      .ir    (ir),
      .imm_c (bus.alu_immediate_data)
   );

   // Instruction decode: legality and EXECUTE-phase ALU setup
   always_comb begin
      dec_legal     = 1'b0;
      dec_writes_rd = 1'b0;
      dec_a         = OPND_RS1;
      dec_b         = OPND_RS2;
      dec_op        = ALU_ADD;
      case (opcode)
         OPC_OP: begin
            dec_writes_rd = 1'b1;
            dec_op        = arith_op(funct3, funct7[5]);
            dec_legal     = (funct7 == FUNCT7_BASE) ||
                            ((funct7 == FUNCT7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
         end
         OPC_OP_IMM: begin
            dec_writes_rd = 1'b1;
            dec_b         = OPND_IMM;
            // Only shift-right immediates carry an alternate-op bit
            dec_op        = arith_op(funct3, (funct3 == 3'b101) && funct7[5]);
            case (funct3)
               3'b001:  dec_legal = (funct7 == FUNCT7_BASE);
               3'b101:  dec_legal = (funct7 == FUNCT7_BASE) || (funct7 == FUNCT7_ALT);
               default: dec_legal = 1'b1;
            endcase
         end
         OPC_LUI: begin
            dec_legal     = 1'b1;
            dec_writes_rd = 1'b1;
            dec_a         = OPND_ZERO;
            dec_b         = OPND_IMM;
         end
         OPC_AUIPC: begin
            dec_legal     = 1'b1;
            dec_writes_rd = 1'b1;
            dec_a         = OPND_PC;
            dec_b         = OPND_IMM;
         end
         OPC_JAL, OPC_JALR: begin
            dec_legal     = 1'b1;
            dec_writes_rd = 1'b1;
            dec_a         = OPND_PC;
            dec_b         = OPND_FOUR;
         end
`ifdef CTRL_BRANCH_EN
         OPC_BRANCH: begin
            dec_legal = (funct3 != 3'b010) && (funct3 != 3'b011);
            dec_op    = branch_op(funct3);
         end
`else
         OPC_BRANCH: dec_legal = 1'b0;
`endif
         default: dec_legal = 1'b0;
      endcase
   end

`ifdef CTRL_BRANCH_EN
   logic taken;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         taken <= 1'b0;
      end else if ((state == ST_EXECUTE) && (opcode == OPC_BRANCH)) begin
         taken <= bus.alu_result[0];
      end
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_FETCH;
         ir    <= NOP_INSTR;
      end else begin
         state <= next_state;
         if ((state == ST_FETCH) && bus.mem_ready) begin
            ir <= bus.mem_rdata;
         end
      end
   end

   // Next state and control strobes
   always_comb begin
      next_state               = state;
      bus.mem_req              = 1'b0;
      bus.reg_bank_load_en     = 1'b0;
      bus.pc_load_en           = 1'b0;
      bus.instr_retired        = 1'b0;
      bus.illegal_instr        = 1'b0;
      bus.bus_clear_lsb        = 1'b0;
      bus.alu_operand_a_select = OPND_PC;
      bus.alu_operand_b_select = OPND_FOUR;
      bus.alu_operation        = ALU_ADD;
      case (state)
         ST_FETCH: begin
            bus.mem_req = 1'b1;
            if (bus.mem_ready) begin
               next_state = ST_DECODE;
            end
         end
         ST_DECODE: begin
            next_state = dec_legal ? ST_EXECUTE : ST_TRAP;
         end
         ST_EXECUTE: begin
            bus.alu_operand_a_select = dec_a;
            bus.alu_operand_b_select = dec_b;
            bus.alu_operation        = dec_op;
            bus.reg_bank_load_en     = dec_writes_rd && (rd != '0);
            next_state               = ST_PC_UPDATE;
         end
         ST_PC_UPDATE: begin
            bus.pc_load_en    = 1'b1;
            bus.instr_retired = 1'b1;
            next_state        = ST_FETCH;
            case (opcode)
               OPC_JAL: bus.alu_operand_b_select = OPND_IMM;
               OPC_JALR: begin
                  bus.alu_operand_a_select = OPND_RS1;
                  bus.alu_operand_b_select = OPND_IMM;
                  bus.bus_clear_lsb        = 1'b1;
               end
`ifdef CTRL_BRANCH_EN
               OPC_BRANCH: begin
                  if (taken) begin
                     bus.alu_operand_b_select = OPND_IMM;
                  end
               end
`endif
               default: ;
            endcase
         end
         ST_TRAP: begin
            bus.illegal_instr = 1'b1;
         end
         default: next_state = ST_FETCH;
      endcase
   end

endmodule

// File: tb/tb_control_unit.sv
// Directed self-checking bench for control_unit; branch vectors depend on CTRL_BRANCH_EN.
module tb_control_unit;
   import control_unit_pkg::*;

   logic clk = 1'b0;
   logic rst;

   control_unit_if bus ();

   control_unit dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   typedef struct {
      string          tag;
      logic [31:0]    word;
      int unsigned    wait_n;
      logic [31:0]    pc;
      logic           alu_bit;
      logic           load;
      logic [4:0]     rd;
      logic [4:0]     rs1;
      logic [4:0]     rs2;
      logic [31:0]    imm;
      alu_operand_t   ea;
      alu_operand_t   eb;
      alu_operation_t eop;
      alu_operand_t   pa;
      alu_operand_t   pb;
      logic           clr;
   } vec_t;

   vec_t vq[$];

   task automatic do_reset();
      rst            = 1'b1;
      bus.mem_ready  = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #1;
      check("rst/load_en",  32'(bus.reg_bank_load_en), 32'd0);
      check("rst/pc_load",  32'(bus.pc_load_en),       32'd0);
      check("rst/retired",  32'(bus.instr_retired),    32'd0);
      check("rst/illegal",  32'(bus.illegal_instr),    32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst/mem_req",  32'(bus.mem_req),          32'd1);
   endtask

   task automatic run_vec(input vec_t v);
      for (int k = 0; k <= int'(v.wait_n); k++) begin
         bus.pc_in     = v.pc;
         bus.mem_ready = (k == int'(v.wait_n));
         bus.mem_rdata = (k == int'(v.wait_n)) ? v.word : 32'h0000_0073;
         #1;
         check({v.tag, "/mem_req"},  32'(bus.mem_req), 32'd1);
         check({v.tag, "/mem_addr"}, bus.mem_addr,     v.pc);
         check({v.tag, "/retired_f"}, 32'(bus.instr_retired), 32'd0);
         @(negedge clk);
      end
      // A trap word offered with ready high outside FETCH must be ignored
      bus.mem_ready = 1'b1;
      bus.mem_rdata = 32'h0000_0073;
      #1;
      check({v.tag, "/dec_mem_req"}, 32'(bus.mem_req),            32'd0);
      check({v.tag, "/dec_imm"},     bus.alu_immediate_data,      v.imm);
      check({v.tag, "/dec_sel_a"},   32'(bus.reg_bank_sel_out_a), 32'(v.rs1));
      check({v.tag, "/dec_sel_b"},   32'(bus.reg_bank_sel_out_b), 32'(v.rs2));
      check({v.tag, "/dec_sel_in"},  32'(bus.reg_bank_sel_in),    32'(v.rd));
      check({v.tag, "/dec_load"},    32'(bus.reg_bank_load_en),   32'd0);
      check({v.tag, "/dec_pc_load"}, 32'(bus.pc_load_en),         32'd0);
      @(negedge clk);
      bus.alu_result = {31'h0, v.alu_bit};
      #1;
      check({v.tag, "/ex_load"},     32'(bus.reg_bank_load_en),     32'(v.load));
      check({v.tag, "/ex_sel_in"},   32'(bus.reg_bank_sel_in),      32'(v.rd));
      check({v.tag, "/ex_opa"},      32'(bus.alu_operand_a_select), 32'(v.ea));
      check({v.tag, "/ex_opb"},      32'(bus.alu_operand_b_select), 32'(v.eb));
      check({v.tag, "/ex_op"},       32'(bus.alu_operation),        32'(v.eop));
      check({v.tag, "/ex_pc_load"},  32'(bus.pc_load_en),           32'd0);
      check({v.tag, "/ex_retired"},  32'(bus.instr_retired),        32'd0);
      @(negedge clk);
      bus.alu_result = {31'h0, ~v.alu_bit};
      #1;
      check({v.tag, "/pc_load"},     32'(bus.pc_load_en),           32'd1);
      check({v.tag, "/pc_retired"},  32'(bus.instr_retired),        32'd1);
      check({v.tag, "/pc_reg_load"}, 32'(bus.reg_bank_load_en),     32'd0);
      check({v.tag, "/pc_opa"},      32'(bus.alu_operand_a_select), 32'(v.pa));
      check({v.tag, "/pc_opb"},      32'(bus.alu_operand_b_select), 32'(v.pb));
      check({v.tag, "/pc_op"},       32'(bus.alu_operation),        32'(ALU_ADD));
      check({v.tag, "/pc_clr"},      32'(bus.bus_clear_lsb),        32'(v.clr));
      @(negedge clk);
      bus.mem_ready = 1'b0;
      #1;
      check({v.tag, "/next_mem_req"}, 32'(bus.mem_req),       32'd1);
      check({v.tag, "/next_retired"}, 32'(bus.instr_retired), 32'd0);
   endtask

   task automatic run_trap(input string tag, input logic [31:0] word);
      bus.mem_ready = 1'b1;
      bus.mem_rdata = word;
      #1;
      check({tag, "/mem_req"}, 32'(bus.mem_req), 32'd1);
      @(negedge clk);
      bus.mem_ready = 1'b0;
      #1;
      check({tag, "/dec_illegal"}, 32'(bus.illegal_instr), 32'd0);
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         bus.mem_ready = 1'b1;
         bus.mem_rdata = NOP_INSTR;
         #1;
         check({tag, "/illegal"}, 32'(bus.illegal_instr),    32'd1);
         check({tag, "/mem_req"}, 32'(bus.mem_req),          32'd0);
         check({tag, "/load"},    32'(bus.reg_bank_load_en), 32'd0);
         check({tag, "/pc_load"}, 32'(bus.pc_load_en),       32'd0);
         check({tag, "/retired"}, 32'(bus.instr_retired),    32'd0);
         @(negedge clk);
      end
      rst = 1'b1;
      #1;
      check({tag, "/rst_clears"}, 32'(bus.illegal_instr), 32'd0);
      @(negedge clk);
      rst           = 1'b0;
      bus.mem_ready = 1'b0;
      #1;
      check({tag, "/refetch"}, 32'(bus.mem_req), 32'd1);
   endtask

   initial begin
      rst            = 1'b1;
      bus.mem_ready  = 1'b0;
      bus.mem_rdata  = '0;
      bus.pc_in      = '0;
      bus.alu_result = '0;

      //        tag      word          wait pc            ab ld rd  rs1 rs2 imm            ea         eb         eop       pa        pb         clr
      vq.push_back('{"addi",  32'h0050_0093, 0, 32'h0000_0000, 1'b0, 1'b1, 5'd1,  5'd0,  5'd5,  32'h0000_0005, OPND_RS1,  OPND_IMM,  ALU_ADD,  OPND_PC,  OPND_FOUR, 1'b0});
      vq.push_back('{"sub_w3", 32'h4020_81B3, 3, 32'h0000_0100, 1'b0, 1'b1, 5'd3,  5'd1,  5'd2,  32'h0000_0000, OPND_RS1,  OPND_RS2,  ALU_SUB,  OPND_PC,  OPND_FOUR, 1'b0});
      vq.push_back('{"jalr",  32'hFFD1_00E7, 1, 32'h0000_0200, 1'b0, 1'b1, 5'd1,  5'd2,  5'd29, 32'hFFFF_FFFD, OPND_PC,   OPND_FOUR, ALU_ADD,  OPND_RS1, OPND_IMM,  1'b1});
      vq.push_back('{"add_x0", 32'h0020_8033, 0, 32'h0000_0204, 1'b0, 1'b0, 5'd0,  5'd1,  5'd2,  32'h0000_0000, OPND_RS1,  OPND_RS2,  ALU_ADD,  OPND_PC,  OPND_FOUR, 1'b0});
      vq.push_back('{"lui",   32'h1234_52B7, 0, 32'h0000_0208, 1'b0, 1'b1, 5'd5,  5'd8,  5'd3,  32'h1234_5000, OPND_ZERO, OPND_IMM,  ALU_ADD,  OPND_PC,  OPND_FOUR, 1'b0});
      vq.push_back('{"auipc", 32'hFFFF_F317, 0, 32'h0000_020C, 1'b0, 1'b1, 5'd6,  5'd31, 5'd31, 32'hFFFF_F000, OPND_PC,   OPND_IMM,  ALU_ADD,  OPND_PC,  OPND_FOUR, 1'b0});
      vq.push_back('{"jal",   32'h0080_00EF, 0, 32'h0000_0210, 1'b0, 1'b1, 5'd1,  5'd0,  5'd8,  32'h0000_0008, OPND_PC,   OPND_FOUR, ALU_ADD,  OPND_PC,  OPND_IMM,  1'b0});
      vq.push_back('{"srai",  32'h4030_D393, 0, 32'h0000_0218, 1'b0, 1'b1, 5'd7,  5'd1,  5'd3,  32'h0000_0403, OPND_RS1,  OPND_IMM,  ALU_SRA,  OPND_PC,  OPND_FOUR, 1'b0});
      vq.push_back('{"sltiu", 32'hFFF0_B413, 0, 32'h0000_021C, 1'b0, 1'b1, 5'd8,  5'd1,  5'd31, 32'hFFFF_FFFF, OPND_RS1,  OPND_IMM,  ALU_SLTU, OPND_PC,  OPND_FOUR, 1'b0});
      vq.push_back('{"addi_neg", 32'hC000_8113, 0, 32'h0000_0220, 1'b0, 1'b1, 5'd2, 5'd1, 5'd0,  32'hFFFF_FC00, OPND_RS1,  OPND_IMM,  ALU_ADD,  OPND_PC,  OPND_FOUR, 1'b0});
      vq.push_back('{"sll",   32'h0020_94B3, 0, 32'h0000_0224, 1'b0, 1'b1, 5'd9,  5'd1,  5'd2,  32'h0000_0000, OPND_RS1,  OPND_RS2,  ALU_SLL,  OPND_PC,  OPND_FOUR, 1'b0});
      vq.push_back('{"sra",   32'h4020_D533, 0, 32'h0000_0228, 1'b0, 1'b1, 5'd10, 5'd1,  5'd2,  32'h0000_0000, OPND_RS1,  OPND_RS2,  ALU_SRA,  OPND_PC,  OPND_FOUR, 1'b0});
`ifdef CTRL_BRANCH_EN
      vq.push_back('{"beq_t", 32'h0020_8863, 0, 32'h0000_0300, 1'b1, 1'b0, 5'd16, 5'd1,  5'd2,  32'h0000_0010, OPND_RS1,  OPND_RS2,  ALU_EQ,   OPND_PC,  OPND_IMM,  1'b0});
      vq.push_back('{"beq_n", 32'h0020_8863, 0, 32'h0000_0304, 1'b0, 1'b0, 5'd16, 5'd1,  5'd2,  32'h0000_0010, OPND_RS1,  OPND_RS2,  ALU_EQ,   OPND_PC,  OPND_FOUR, 1'b0});
      vq.push_back('{"bltu_t", 32'h0020_E863, 1, 32'h0000_0308, 1'b1, 1'b0, 5'd16, 5'd1, 5'd2,  32'h0000_0010, OPND_RS1,  OPND_RS2,  ALU_LTU,  OPND_PC,  OPND_IMM,  1'b0});
`endif

      do_reset();
      foreach (vq[i]) run_vec(vq[i]);

      // Reset while a register write is being strobed
      bus.pc_in     = 32'h0000_0400;
      bus.mem_ready = 1'b1;
      bus.mem_rdata = 32'h0050_0093;
      @(negedge clk);
      bus.mem_ready = 1'b0;
      @(negedge clk);
      #1;
      check("midrst/ex_load", 32'(bus.reg_bank_load_en), 32'd1);
      #1;
      rst = 1'b1;
      #1;
      check("midrst/load_drop", 32'(bus.reg_bank_load_en), 32'd0);
      check("midrst/pc_drop",   32'(bus.pc_load_en),       32'd0);
      @(negedge clk);
      @(negedge clk);
      #1;
      check("midrst/pc_held",   32'(bus.pc_load_en),       32'd0);
      rst = 1'b0;
      run_vec(vq[0]);

      run_trap("ecall",  32'h0000_0073);
      run_trap("mul",    32'h0220_8033);
      run_trap("slli_f7", 32'h4010_9093);
      run_trap("load",   32'h0000_2083);
      run_trap("fence",  32'h0000_000F);
`ifdef CTRL_BRANCH_EN
      run_trap("b_f3_010", 32'h0020_A863);
`else
      run_trap("beq_off", 32'h0020_8863);
`endif
      run_vec(vq[3]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/control_unit.md
# control_unit

Multi-cycle fetch/decode/sequencing controller for the RV32I core; sits directly upstream of the register bank, program counter and ALU. Fetches one instruction word through a ready-handshake memory port, latches it in an internal instruction register, and drives register selects, ALU operand/operation selects, immediate, data-bus writeback and PC load, one instruction at a time.

## Interface
- No parameters.
- clk  in  1  core clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- mem_req  out  1  instruction fetch request
- mem_addr  out  32  fetch address, equals pc_in
- mem_ready  in  1  fetch complete; mem_rdata valid this cycle
- mem_rdata  in  32  fetched instruction word
- pc_in  in  32  current PC register value
- alu_result  in  32  ALU result; bit 0 is the branch-compare outcome
- reg_bank_sel_out_a / reg_bank_sel_out_b  out  5  rs1 / rs2 read selects
- reg_bank_sel_in  out  5  rd write select
- reg_bank_load_en  out  1  register write strobe
- pc_load_en  out  1  PC write strobe
- alu_immediate_data  out  32  sign-extended immediate
- alu_operand_a_select / alu_operand_b_select  out  alu_operand_t  ALU operand selects
- alu_operation  out  alu_operation_t  ALU operation
- bus_clear_lsb  out  1  core data-bus mux forces bit 0 to zero (JALR target)
- instr_retired  out  1  one-cycle pulse per completed instruction
- illegal_instr  out  1  sticky; controller halted on unsupported encoding

## Operation
- States: FETCH, DECODE, EXECUTE, PC_UPDATE, TRAP.
- FETCH: mem_req=1, mem_addr=pc_in; hold until mem_ready=1; then IR<=mem_rdata, go DECODE.
- DECODE: rs1/rs2 selects and immediate driven combinationally from IR (valid from DECODE onward). Opcode legal -> EXECUTE; otherwise -> TRAP.
- EXECUTE (rd write, reg_bank_load_en=1 only if rd!=0; sel_in=rd):
  - OP: RS1 op RS2; OP-IMM: RS1 op IMM (funct3/funct7 decode; SUB/SRA via funct7[5], only for OP / shifts).
  - LUI: ZERO+IMM; AUIPC: PC+IMM; JAL/JALR: PC+FOUR.
  - Go PC_UPDATE.
- PC_UPDATE: pc_load_en=1, instr_retired=1, go FETCH.
  - Default: PC+FOUR. JAL: PC+IMM. JALR: RS1+IMM with bus_clear_lsb=1.
- TRAP: all strobes 0, mem_req 0, illegal_instr=1; exits only on reset.
- Immediates: I/U/J (and B with macro) formats, sign-extended from IR[31]; U-type low 12 bits zero.
- Unused funct7 bits in OP/shift encodings -> illegal. SYSTEM, FENCE, LOAD, STORE -> illegal.

## Timing
- Reset (async): state FETCH, IR=0x00000013, taken=0; all strobes 0, illegal_instr=0. mem_req=1 from first cycle after reset release.
- Minimum latency per instruction: 4 cycles (FETCH with mem_ready same cycle, DECODE, EXECUTE, PC_UPDATE); each FETCH wait cycle adds one.
- mem_addr stable while mem_req=1; mem_rdata sampled only on mem_ready=1 in FETCH; mem_ready outside FETCH ignored.
- Register write occurs before PC update, so JALR with rd==rs1 uses the written value; this is the defined behaviour.
- Reset asserted mid-instruction: strobes drop immediately, no partial writes after release.

## Configuration
- CTRL_BRANCH_EN defined: BRANCH opcode legal; EXECUTE drives RS1 cmp RS2 (EQ/NE/LT/GE/LTU/GEU), no rd write, latches taken<=alu_result[0]; PC_UPDATE uses PC+IMM if taken else PC+FOUR. funct3 010/011 illegal.
- Undefined: BRANCH opcode -> TRAP.

## Structure
- Shared package holds alu_operand_t (RS1, RS2, IMM, PC, ZERO, FOUR), alu_operation_t (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, plus compare ops), RV32I opcode constants, and the control state enum.
- One sub-module: imm_gen (combinational IR -> immediate by format).

## Test plan
- ADDI x1,x0,5 at PC 0, mem_ready immediate -> cycle 3 write sel_in=1 with ZERO... RS1+IMM imm=5; cycle 4 pc_load_en, PC+FOUR, instr_retired.
- mem_ready delayed 3 cycles -> mem_req/mem_addr held constant, retire at cycle 7.
- JALR x1,x2,-3 -> rd write PC+FOUR; PC_UPDATE RS1+IMM imm=0xFFFFFFFD with bus_clear_lsb=1.
- ADD x0,x1,x2 -> reg_bank_load_en stays 0, instruction still retires.
- Word 0x00000073 -> TRAP, illegal_instr=1, no further mem_req until reset; reset clears it.
- With CTRL_BRANCH_EN, BEQ offset +16, alu_result[0]=1 -> PC+IMM; alu_result[0]=0 -> PC+FOUR.
